// File: rtl/addsub_seq_if.sv
// Command, adder and result signals of the addsub sequencer.
// The sequencer uses the slave modport; the environment that feeds it uses master.
interface addsub_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_sub;
  logic        cmd_wide;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic        add_sub;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_c;
  logic        res_v;
  logic        res_n;
  logic        res_z;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sub, cmd_wide, add_sum, add_cout, res_ready,
    output cmd_ready, add_a, add_b, add_cin, add_sub,
    output res_valid, res_data, res_c, res_v, res_n, res_z
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sub, cmd_wide, add_sum, add_cout, res_ready,
    input  cmd_ready, add_a, add_b, add_cin, add_sub,
    input  res_valid, res_data, res_c, res_v, res_n, res_z
  );
endinterface

// File: rtl/addsub_seq.sv
// Byte-serial 8/16-bit add/subtract sequencer around an external 8-bit addsub adder.
// Holds the result and C/V/N/Z flags on a valid/ready output until consumed.
module addsub_seq (
  input logic           clk,
  input logic           rst,
  addsub_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;
  logic        wide_q;
  logic        carry_q;
  logic [15:0] res_q;
  logic        c_q;
  logic        v_q;
  logic        n_q;
  logic        z_q;

  logic        v_lo;
  logic        v_hi;

  // Overflow when operands (B as seen by the adder) agree in sign but the result does not.
  always_comb begin
    v_lo = (a_q[7] == (b_q[7] ^ sub_q)) && (bus.add_sum[7] != a_q[7]);
    v_hi = (a_q[15] == (b_q[15] ^ sub_q)) && (bus.add_sum[7] != a_q[15]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      wide_q  <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            a_q     <= bus.cmd_a;
            b_q     <= bus.cmd_b;
            sub_q   <= bus.cmd_sub;
            wide_q  <= bus.cmd_wide;
            state_q <= StLo;
          end
        end
        StLo: begin
          res_q[7:0] <= bus.add_sum;
          carry_q    <= bus.add_cout;
          if (wide_q) begin
            state_q <= StHi;
          end else begin
            res_q[15:8] <= 8'h00;
            c_q         <= bus.add_cout;
            v_q         <= v_lo;
            n_q         <= bus.add_sum[7];
            z_q         <= (bus.add_sum == 8'h00);
            state_q     <= StDone;
          end
        end
        StHi: begin
          res_q[15:8] <= bus.add_sum;
          c_q         <= bus.add_cout;
          v_q         <= v_hi;
          n_q         <= bus.add_sum[7];
          z_q         <= ({bus.add_sum, res_q[7:0]} == 16'h0000);
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.res_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.add_a   = 8'h00;
    bus.add_b   = 8'h00;
    bus.add_cin = 1'b0;
    bus.add_sub = 1'b0;
    unique case (state_q)
      StLo: begin
        bus.add_a   = a_q[7:0];
        bus.add_b   = b_q[7:0];
        bus.add_sub = sub_q;
        bus.add_cin = sub_q;
      end
      StHi: begin
        bus.add_a   = a_q[15:8];
        bus.add_b   = b_q[15:8];
        bus.add_sub = sub_q;
        bus.add_cin = carry_q;
      end
      default: ;
    endcase
  end

  // Ready is masked by reset so a command presented alongside rst is never taken.
  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign bus.res_valid = (state_q == StDone);
  assign bus.res_data  = res_q;
  assign bus.res_c     = c_q;
  assign bus.res_v     = v_q;
  assign bus.res_n     = n_q;
  assign bus.res_z     = z_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: models the 8-bit adder, runs directed vectors with literal
// expectations, and compares every cycle against a transaction-level model.
module tb_addsub_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic chk_en;

  addsub_seq_if bus ();

  addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit adder the sequencer drives.
  logic [8:0] adder_full;
  assign adder_full   = {1'b0, bus.add_a} + {1'b0, bus.add_b ^ {8{bus.add_sub}}}
                        + {8'h00, bus.add_cin};
  assign bus.add_sum  = adder_full[7:0];
  assign bus.add_cout = adder_full[8];

  typedef struct packed {
    logic [15:0] data;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } res_t;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic wide);
    res_t       r;
    logic [16:0] f;
    logic [15:0] bb;
    int         msb;
    bb  = sub ? ~b : b;
    if (wide) begin
      f   = {1'b0, a} + {1'b0, bb} + {16'h0000, sub};
      msb = 15;
    end else begin
      f   = {8'h00, {1'b0, a[7:0]} + {1'b0, bb[7:0]} + {8'h00, sub}};
      f   = {8'h00, f[8:0]};
      msb = 7;
    end
    r.data = wide ? f[15:0] : {8'h00, f[7:0]};
    r.c    = wide ? f[16] : f[8];
    r.n    = r.data[msb];
    r.v    = (a[msb] == (b[msb] ^ sub)) && (r.data[msb] != a[msb]);
    r.z    = (r.data == 16'h0000);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending result and cycles remaining before it becomes valid.
  logic        m_idle;
  logic        m_pend;
  int          m_wait;
  res_t        m_exp;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_sub;
  logic        m_wide;

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_pend <= 1'b0;
      m_wait <= 0;
    end else if (m_idle) begin
      if (bus.cmd_valid) begin
        m_idle <= 1'b0;
        m_wait <= bus.cmd_wide ? 2 : 1;
        m_exp  <= model(bus.cmd_a, bus.cmd_b, bus.cmd_sub, bus.cmd_wide);
        m_a    <= bus.cmd_a;
        m_b    <= bus.cmd_b;
        m_sub  <= bus.cmd_sub;
        m_wide <= bus.cmd_wide;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_pend <= 1'b1;
    end else if (m_pend && bus.res_ready) begin
      m_pend <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [17:0] exp_add;
      logic [8:0]  lo_sum;
      lo_sum = {1'b0, m_a[7:0]} + {1'b0, m_b[7:0] ^ {8{m_sub}}} + {8'h00, m_sub};
      if (m_wait == 0)
        exp_add = '0;
      else if (m_wait == (m_wide ? 2 : 1))
        exp_add = {m_a[7:0], m_b[7:0], m_sub, m_sub};
      else
        exp_add = {m_a[15:8], m_b[15:8], lo_sum[8], m_sub};
      check("mdl_cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, m_idle && !rst});
      check("mdl_res_valid", {31'd0, bus.res_valid}, {31'd0, m_pend});
      check("mdl_adder_in", {14'd0, bus.add_a, bus.add_b, bus.add_cin, bus.add_sub},
            {14'd0, exp_add});
      if (m_pend)
        check("mdl_result", {12'd0, bus.res_data, bus.res_c, bus.res_v, bus.res_n, bus.res_z},
              {12'd0, m_exp});
    end
  end

  logic last_hi_cin;

  // Issues one command from idle; `hold` cycles of back-pressure before the handshake.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic wide, input int hold,
                        input logic [15:0] ed, input logic ec, input logic ev,
                        input logic en, input logic ez);
    int   n;
    res_t held;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sub   = sub;
    bus.cmd_wide  = wide;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = ~a;
    bus.cmd_b     = 16'h5A5A;
    bus.cmd_sub   = ~sub;
    bus.cmd_wide  = ~wide;
    n = 0;
    last_hi_cin = 1'b0;
    while (!bus.res_valid && n < 8) begin
      if (n == 1) last_hi_cin = bus.add_cin;
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_latency"}, n, wide ? 2 : 1);
    check({nm, "_result"}, {12'd0, bus.res_data, bus.res_c, bus.res_v, bus.res_n, bus.res_z},
          {12'd0, ed, ec, ev, en, ez});
    held = {bus.res_data, bus.res_c, bus.res_v, bus.res_n, bus.res_z};
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 16'h0F0F + 16'(i);
      @(posedge clk);
      #1;
      check({nm, "_hold_valid"}, {31'd0, bus.res_valid}, 32'd1);
      check({nm, "_hold_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
      check({nm, "_hold_data"}, {12'd0, bus.res_data, bus.res_c, bus.res_v, bus.res_n,
            bus.res_z}, {12'd0, held});
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({nm, "_idle_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    check({nm, "_idle_valid"}, {31'd0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    chk_en        = 1'b0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sub   = 1'b0;
    bus.cmd_wide  = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_outputs", {8'd0, bus.res_valid, bus.cmd_ready, bus.res_data, bus.res_c,
          bus.res_v, bus.res_n, bus.res_z}, 32'd0);
    check("rst_adder", {14'd0, bus.add_a, bus.add_b, bus.add_cin, bus.add_sub}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;

    run_op("n_add_7f", 16'h007F, 16'h0001, 1'b0, 1'b0, 0, 16'h0080, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("w_add_ff", 16'h00FF, 16'h0001, 1'b0, 1'b1, 0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w_add_ff_hi_cin", {31'd0, last_hi_cin}, 32'd1);
    run_op("w_sub_1000", 16'h1000, 16'h0001, 1'b1, 1'b1, 0, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("n_sub_00", 16'h0000, 16'h0001, 1'b1, 1'b0, 0, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("w_sub_8000", 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("n_add_ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("w_add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("w_add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("n_sub_hi", 16'hAB80, 16'hCD01, 1'b1, 1'b0, 0, 16'h007F, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("bp_hold", 16'h1234, 16'h4321, 1'b0, 1'b1, 5, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("bp_next", 16'h0003, 16'h0005, 1'b1, 1'b0, 0, 16'h00FE, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort a wide op in its high-byte cycle, with a command presented during reset.
    bus.cmd_a     = 16'h1234;
    bus.cmd_b     = 16'h1111;
    bus.cmd_sub   = 1'b0;
    bus.cmd_wide  = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_hi", {24'd0, bus.add_a}, 32'h12);
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", {8'd0, bus.res_valid, bus.cmd_ready, bus.res_data, bus.res_c,
          bus.res_v, bus.res_n, bus.res_z}, 32'd0);
    check("abort_adder", {14'd0, bus.add_a, bus.add_b, bus.add_cin, bus.add_sub}, 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {31'd0, bus.res_valid}, 32'd0);
    end
    run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b1, 0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
